// File: rtl/rgb_pwm_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared definitions for the multi-channel RGB PWM driver: channel mode
// encodings, named color constants and a helper that sizes the channel
// index field.
// ---------------------------------------------------------------------------
package rgb_pwm_pkg;

    // Per-channel operating mode as written through the settings port
    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    // {R,G,B} enable patterns
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] WHITE = 3'b111;

    // Width of the channel index; a single channel still needs one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One RGB channel: shadow and active settings, mode decode, duty compare and
// the registered color output.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   we            decoded write strobe for this channel
//   wr_color      {R,G,B} enable to write
//   wr_duty       duty value to write
//   wr_mode       mode to write (rgb_pwm_pkg::mode_t encoding)
//   c             shared PWM counter
//   blink_msb     blink phase; channel is dark in BLINK mode while high
//   tri_val       triangular ramp level used by BREATHE mode
//   boundary      high on the edge that ends a PWM period
//   rgb           registered color output of this channel
// ---------------------------------------------------------------------------
module pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [2:0]   wr_color,
    input  logic [W-1:0] wr_duty,
    input  logic [1:0]   wr_mode,
    input  logic [W-1:0] c,
    input  logic         blink_msb,
    input  logic [W-1:0] tri_val,
    input  logic         boundary,
    output logic [2:0]   rgb
);

    logic [2:0]   shadow_color;
    logic [W-1:0] shadow_duty;
    mode_t        shadow_mode;
    logic [2:0]   active_color;
    logic [W-1:0] active_duty;
    mode_t        active_mode;

    logic [W-1:0] duty_eff;
    logic         on;

    // Writes land in the shadow set at any time; the active set only changes
    // on the period boundary so a period never mixes old and new settings.
    // A write coinciding with the boundary bypasses the shadow so it is not
    // delayed by a whole extra period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_color <= '0;
            shadow_duty  <= '0;
            shadow_mode  <= MODE_OFF;
            active_color <= '0;
            active_duty  <= '0;
            active_mode  <= MODE_OFF;
            rgb          <= '0;
        end else begin
            if (we) begin
                shadow_color <= wr_color;
                shadow_duty  <= wr_duty;
                shadow_mode  <= mode_t'(wr_mode);
            end
            if (boundary) begin
                active_color <= we ? wr_color : shadow_color;
                active_duty  <= we ? wr_duty : shadow_duty;
                active_mode  <= we ? mode_t'(wr_mode) : shadow_mode;
            end
            rgb <= {3{on}} & active_color;
        end
    end

    // Breathing clamps the ramp at the programmed duty so the peak
    // brightness follows the duty setting.
    always_comb begin
        duty_eff = (tri_val < active_duty) ? tri_val : active_duty;
        on       = 1'b0;
        case (active_mode)
            MODE_SOLID:   on = (c < active_duty);
            MODE_BLINK:   on = (c < active_duty) && !blink_msb;
            MODE_BREATHE: on = (c < duty_eff);
            default:      on = 1'b0;
        endcase
    end

endmodule

// File: rtl/rgb_pwm_multi.sv
// ---------------------------------------------------------------------------
// rgb_pwm_multi
// Drives NCH RGB LEDs from one shared PWM timebase. Each channel has its own
// color, duty and mode, updated glitch-free at PWM period boundaries.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   wr_en       one-cycle write strobe for channel settings
//   wr_ch       channel index; indices >= NCH are ignored
//   wr_color    {R,G,B} enable
//   wr_duty     duty; on-time = duty / 2^W of the period
//   wr_mode     0=OFF 1=SOLID 2=BLINK 3=BREATHE
//   RGB         channel i on RGB[3i+2:3i], registered
//   period_end  one-cycle pulse on the first cycle of each period
// ---------------------------------------------------------------------------
module rgb_pwm_multi
    import rgb_pwm_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W   = 8,
    parameter int PRE = 8,
    parameter int BLK = 6,
    localparam int CW = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_ch,
    input  logic [2:0]       wr_color,
    input  logic [W-1:0]     wr_duty,
    input  logic [1:0]       wr_mode,
    output logic [3*NCH-1:0] RGB,
    output logic             period_end
);

    logic [PRE-1:0] p;
    logic [W-1:0]   c;
    logic [BLK-1:0] b;
    logic [W:0]     r;
    logic           tick;
    logic           boundary;
    logic [W-1:0]   tri_val;

    assign tick     = &p;
    assign boundary = tick && (&c);

    // Ramp folds at its midpoint: counts up through the lower half of r,
    // then back down through the upper half.
    assign tri_val  = r[W] ? ~r[W-1:0] : r[W-1:0];

    // Shared timebase: prescaler, PWM counter, and the per-period blink and
    // ramp counters that all advance together when the PWM counter wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p          <= '0;
            c          <= '0;
            b          <= '0;
            r          <= '0;
            period_end <= 1'b0;
        end else begin
            p          <= p + 1'b1;
            period_end <= boundary;
            if (tick) begin
                c <= c + 1'b1;
            end
            if (boundary) begin
                b <= b + 1'b1;
                r <= r + 1'b1;
            end
        end
    end

    // One channel slice per LED; the write decode lives here so an index
    // beyond NCH simply matches no slice.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic we;
        assign we = wr_en && (wr_ch == CW'(i));

        pwm_channel #(
            .W (W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .we        (we),
            .wr_color  (wr_color),
            .wr_duty   (wr_duty),
            .wr_mode   (wr_mode),
            .c         (c),
            .blink_msb (b[BLK-1]),
            .tri_val   (tri_val),
            .boundary  (boundary),
            .rgb       (RGB[3*i +: 3])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_multi
// Directed bench for rgb_pwm_multi with W=4, PRE=1, BLK=2 (32-clk periods).
// A second, single-channel instance covers the ignored out-of-range write.
// ---------------------------------------------------------------------------
module tb_rgb_pwm_multi;
    import rgb_pwm_pkg::*;

    localparam int NCH = 2;
    localparam int W   = 4;
    localparam int PRE = 1;
    localparam int BLK = 2;
    localparam int PER = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en;
    logic [0:0]       wr_ch;
    logic [2:0]       wr_color;
    logic [W-1:0]     wr_duty;
    logic [1:0]       wr_mode;
    logic [3*NCH-1:0] rgb;
    logic             period_end;

    logic             w1_en;
    logic [0:0]       w1_ch;
    logic [2:0]       rgb1;
    logic             pe1;

    int vectors     = 0;
    int miscompares = 0;
    int pe_count    = 0;

    always #5 clk = ~clk;

    rgb_pwm_multi #(.NCH(NCH), .W(W), .PRE(PRE), .BLK(BLK)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_color   (wr_color),
        .wr_duty    (wr_duty),
        .wr_mode    (wr_mode),
        .RGB        (rgb),
        .period_end (period_end)
    );

    rgb_pwm_multi #(.NCH(1), .W(W), .PRE(PRE), .BLK(BLK)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (w1_en),
        .wr_ch      (w1_ch),
        .wr_color   (wr_color),
        .wr_duty    (wr_duty),
        .wr_mode    (wr_mode),
        .RGB        (rgb1),
        .period_end (pe1)
    );

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge; write strobes last one cycle and the
    // period counter mirrors the design's blink/ramp counters.
    task automatic stepCycle();
        @(negedge clk);
        wr_en = 1'b0;
        w1_en = 1'b0;
        if (rst && period_end) pe_count++;
    endtask

    // Present a write to the main instance; captured on the next rising edge
    task automatic applyStimulus(input int ch, input logic [2:0] color,
                                 input int duty, input logic [1:0] mode);
        wr_ch    = 1'(ch);
        wr_color = color;
        wr_duty  = W'(duty);
        wr_mode  = mode;
        wr_en    = 1'b1;
    endtask

    // Step until the next period_end sample, bounded
    task automatic syncPeriod();
        int k = 0;
        do begin
            stepCycle();
            k++;
        end while (!period_end && k < 100);
        if (!period_end) checkOutput("sync_timeout", 0, 1);
    endtask

    // From a period_end sample, observe one full period of one channel
    task automatic measurePeriod(input int ch, input logic [2:0] color, output int on_cnt);
        int bad = 0;
        int early = 0;
        logic [2:0] slice;
        on_cnt = 0;
        for (int n = 1; n <= PER; n++) begin
            stepCycle();
            slice = rgb[3*ch +: 3];
            if (color != 3'b000 && slice == color) on_cnt++;
            else if (slice != 3'b000) bad++;
            if (n < PER && period_end) early++;
        end
        checkOutput($sformatf("ch%0d_color", ch), bad, 0);
        checkOutput("pe_early", early, 0);
        checkOutput("pe_spacing", int'(period_end), 1);
    endtask

    function automatic int triOf(input int cnt);
        int rv;
        rv = cnt % 32;
        return (rv < 16) ? rv : 31 - rv;
    endfunction

    function automatic int minOf(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        int on;
        int k;
        int nz;
        int bv;

        wr_en = 1'b0; wr_ch = '0; wr_color = '0; wr_duty = '0; wr_mode = '0;
        w1_en = 1'b0; w1_ch = '0;

        // Reset held with random write traffic: everything stays quiet
        nz = 0;
        for (int i = 0; i < 40; i++) begin
            wr_en    = 1'b1;
            wr_ch    = 1'($urandom_range(0, 1));
            wr_color = 3'($urandom);
            wr_duty  = W'($urandom);
            wr_mode  = 2'($urandom);
            w1_en    = 1'b1;
            w1_ch    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rgb != 0 || period_end || rgb1 != 0 || pe1) nz++;
        end
        checkOutput("reset_quiet", nz, 0);
        wr_en = 1'b0;
        w1_en = 1'b0;
        pe_count = 0;
        rst = 1'b1;

        // First period_end comes 32 clk after release
        k = 0;
        do begin
            stepCycle();
            k++;
        end while (!period_end && k < 100);
        checkOutput("first_pe", k, 32);

        measurePeriod(0, WHITE, on);
        checkOutput("ch0_off_after_reset", on, 0);

        // SOLID, duty 4: pending for the current period, then 8 of 32
        applyStimulus(0, 3'b101, 4, MODE_SOLID);
        measurePeriod(0, 3'b101, on);
        checkOutput("solid_pending", on, 0);
        measurePeriod(0, 3'b101, on);
        checkOutput("solid_duty4", on, 8);
        measurePeriod(1, WHITE, on);
        checkOutput("ch1_untouched", on, 0);

        // Mid-period duty change waits for the boundary
        applyStimulus(0, 3'b101, 12, MODE_SOLID);
        measurePeriod(0, 3'b101, on);
        checkOutput("shadow_old", on, 8);
        measurePeriod(0, 3'b101, on);
        checkOutput("shadow_new", on, 24);

        // Write on the boundary edge applies to the very next period
        for (int i = 0; i < PER - 1; i++) stepCycle();
        applyStimulus(0, 3'b101, 4, MODE_SOLID);
        stepCycle();
        checkOutput("boundary_pulse", int'(period_end), 1);
        measurePeriod(0, 3'b101, on);
        checkOutput("boundary_write", on, 8);

        // Back-to-back writes: the last one wins
        applyStimulus(0, 3'b101, 2, MODE_SOLID);
        stepCycle();
        applyStimulus(0, 3'b101, 6, MODE_SOLID);
        syncPeriod();
        measurePeriod(0, 3'b101, on);
        checkOutput("last_write_wins", on, 12);

        // BLINK: 16 clk on while blink phase bit is clear, dark otherwise
        applyStimulus(1, WHITE, 8, MODE_BLINK);
        syncPeriod();
        for (int i = 0; i < 4; i++) begin
            bv = pe_count % 4;
            measurePeriod(1, WHITE, on);
            checkOutput($sformatf("blink_b%0d", bv), on, (bv >= 2) ? 0 : 16);
        end

        // BREATHE with full duty: on-time follows 2*tri over a full ramp
        applyStimulus(0, WHITE, 15, MODE_BREATHE);
        syncPeriod();
        for (int i = 0; i < 32; i++) begin
            bv = pe_count;
            measurePeriod(0, WHITE, on);
            checkOutput($sformatf("breathe15_r%0d", bv % 32), on, 2 * minOf(triOf(bv), 15));
        end

        // BREATHE with duty 6 clamps at 12 clk
        applyStimulus(0, WHITE, 6, MODE_BREATHE);
        syncPeriod();
        for (int i = 0; i < 16; i++) begin
            bv = pe_count;
            measurePeriod(0, WHITE, on);
            checkOutput($sformatf("breathe6_r%0d", bv % 32), on, 2 * minOf(triOf(bv), 6));
        end

        // Duty extremes in SOLID
        applyStimulus(0, WHITE, 0, MODE_SOLID);
        syncPeriod();
        measurePeriod(0, WHITE, on);
        checkOutput("duty0", on, 0);
        applyStimulus(0, WHITE, 15, MODE_SOLID);
        syncPeriod();
        measurePeriod(0, WHITE, on);
        checkOutput("duty15", on, 30);

        // Zero color stays dark even when on
        applyStimulus(1, BLACK, 15, MODE_SOLID);
        syncPeriod();
        measurePeriod(1, BLACK, on);
        checkOutput("color_black", on, 0);

        // Single-channel instance: index 1 is ignored, index 0 works
        wr_color = WHITE; wr_duty = W'(15); wr_mode = MODE_SOLID;
        w1_ch = 1'b1; w1_en = 1'b1;
        syncPeriod();
        nz = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            stepCycle();
            if (rgb1 != 0) nz++;
        end
        checkOutput("nch1_ignored", nz, 0);
        w1_ch = 1'b0; w1_en = 1'b1;
        syncPeriod();
        on = 0;
        for (int i = 0; i < PER; i++) begin
            stepCycle();
            if (rgb1 == WHITE) on++;
        end
        checkOutput("nch1_ch0", on, 30);

        // Asynchronous reset mid-period clears outputs without a clock edge
        applyStimulus(1, WHITE, 15, MODE_SOLID);
        syncPeriod();
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("pre_reset_ch1", int'(rgb[5:3]), 7);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rgb", int'(rgb), 0);
        checkOutput("async_pe", int'(period_end), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
